cache_set_nway: RTL and testbench
=================================

# cache_set_nway

Parametrised N-way set of the set-associative cache: holds WAYS lines of tag, valid bit and WORDS_PER_LINE data words, performs registered tag lookup, word read/write on hit, and on a miss requests a line fill from the next memory level, selects a victim, installs the line and completes the request. It sits between the cache controller (request side) and main memory (fill side) and replaces the fixed 8-way combinational set with a sequential, handshaked block.

## Interface
- WAYS, 8, number of ways; power of two, ≥2
- TAG_W, 25, tag width
- WORD_W, 32, data word width
- WORDS_PER_LINE, 16, words per line; power of two; OFF_W = log2(WORDS_PER_LINE)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears valids, replacement state, FSM
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; reset value 1
- req_write  in  1  1 = word write, 0 = read
- req_tag  in  TAG_W  request tag
- req_offset  in  OFF_W  word index within line
- req_wdata  in  WORD_W  write data
- flush  in  1  invalidate all ways (IDLE only)
- resp_valid  out  1  one-cycle completion pulse; reset 0
- resp_hit  out  1  1 = served without fill; reset 0
- resp_rdata  out  WORD_W  addressed word after any write; reset 0
- fill_req  out  1  level, held until fill_valid sampled; reset 0
- fill_tag  out  TAG_W  tag of line to fetch; reset 0
- fill_valid  in  1  fill data present (single cycle)
- fill_data  in  WORDS_PER_LINE*WORD_W  line, word i at bits [i*WORD_W +: WORD_W]
- way_valid  out  WAYS  per-way valid bits; reset 0

## Operation
- FSM states: IDLE, LOOKUP, FILL, RESP; reset → IDLE.
- IDLE: flush high → all valids cleared at the edge, request not accepted. Else req_valid high → tag/offset/write/wdata registered, → LOOKUP.
- LOOKUP: compare registered tag against all valid ways. Hit → way selected (lowest index if several); write updates the word; → RESP with resp_hit=1. Miss → victim chosen, fill_tag = registered tag, → FILL.
- Victim: lowest-index invalid way; if all valid, replacement policy (see Configuration).
- FILL: fill_req=1. On fill_valid: victim line ← fill_data, tag stored, valid set; if write, addressed word ← req_wdata instead of fill word (write-allocate); → RESP with resp_hit=0.
- RESP: resp_valid=1, resp_rdata = addressed word of hit/filled way; → IDLE.
- Replacement state updated on every hit and every fill.
- fill_valid outside FILL ignored. flush outside IDLE ignored.

## Timing
- Request accepted at edge ending cycle T: LOOKUP in T+1, hit response (resp_valid) in T+2, req_ready high again in T+3.
- Miss: fill_req high from T+2; fill_valid sampled in cycle F (≥T+2) → line written at end of F, resp_valid in F+1, fill_req low in F+1.
- Back-to-back hits: one request per 3 cycles.
- Write hit: word written at end of T+1; resp_rdata in T+2 shows written data.
- Reset mid-operation (any state): immediately fill_req=0, resp_valid=0, req_ready=1, way_valid=0; in-flight request discarded; later fill_valid ignored.

## Configuration
- CACHE_SET_LRU_EN defined: true LRU. Per-way age of log2(WAYS) bits, reset age[i]=i. On access to way w: ways with age < age[w] increment, age[w]←0. Victim = way with age WAYS-1.
- Undefined: round-robin pointer, reset 0; victim = pointer; pointer increments (wrapping WAYS-1→0) only on fills that replace a valid way. No age storage.

## Test plan
- Defaults. After reset, read tag 0x0000123 offset 3 → fill_req at T+2, fill_tag 0x0000123; fill_valid with word3=0xDEADBEEF → resp_valid at F+1, resp_rdata 0xDEADBEEF, resp_hit 0, way_valid 8'h01.
- Repeat same read → resp_valid at T+2, resp_hit 1, rdata 0xDEADBEEF, fill_req stays 0.
- Write hit tag 0x0000123 offset 3 wdata 0x12345678, then read → rdata 0x12345678, resp_hit 1; write-miss tag 0x0000200 offset 0 wdata 0xA5A5A5A5 → filled line word0 reads 0xA5A5A5A5.
- Fill tags 0..7 into ways 0..7, hit tag 0, then miss tag 8: with CACHE_SET_LRU_EN way1 replaced (tag 1 misses, tag 0 hits); without, way0 replaced (tag 0 misses).
- Reset pulsed during FILL → fill_req 0 and way_valid 0 same cycle, req_ready 1; subsequent fill_valid pulse causes no resp_valid.
- flush in IDLE with 8 valid ways → way_valid 0 next cycle; read tag 0x0000123 then misses.

Source files
------------

// File: rtl/cache_set_nway.sv
// One N-way set of a set-associative cache with registered tag lookup and a line-fill handshake.
// Optional feature: define CACHE_SET_LRU_EN for true-LRU replacement (default build uses round-robin).
module cache_set_nway #(
    parameter int WAYS           = 8,
    parameter int TAG_W          = 25,
    parameter int WORD_W         = 32,
    parameter int WORDS_PER_LINE = 16,
    localparam int OFF_W         = $clog2(WORDS_PER_LINE),
    localparam int WAY_W         = $clog2(WAYS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [TAG_W-1:0]                 req_tag,
    input  logic [OFF_W-1:0]                 req_offset,
    input  logic [WORD_W-1:0]                req_wdata,
    input  logic                             flush,
    output logic                             resp_valid,
    output logic                             resp_hit,
    output logic [WORD_W-1:0]                resp_rdata,
    output logic                             fill_req,
    output logic [TAG_W-1:0]                 fill_tag,
    input  logic                             fill_valid,
    input  logic [WORDS_PER_LINE*WORD_W-1:0] fill_data,
    output logic [WAYS-1:0]                  way_valid
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                req_write_q, req_write_d;
    logic [TAG_W-1:0]    req_tag_q, req_tag_d;
    logic [OFF_W-1:0]    req_off_q, req_off_d;
    logic [WORD_W-1:0]   req_wdata_q, req_wdata_d;
    logic [WAYS-1:0]     valid_q, valid_d;
    logic [WAY_W-1:0]    victim_q, victim_d;
    logic [WORD_W-1:0]   rdata_q, rdata_d;
    logic                hit_q, hit_d;
    logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;

    // Line storage is not reset; valid bits alone decide what is meaningful.
    logic [TAG_W-1:0]    tag_mem  [WAYS];
    logic [WORD_W-1:0]   data_mem [WAYS][WORDS_PER_LINE];

    logic                hit;
    logic [WAY_W-1:0]    hit_way;
    logic                inv_found;
    logic [WAY_W-1:0]    inv_way;
    logic [WAY_W-1:0]    policy_victim;
    logic                line_we;
    logic                word_we;
    logic                acc_en;
    logic [WAY_W-1:0]    acc_way;

    assign req_ready  = (state_q == S_IDLE);
    assign fill_req   = (state_q == S_FILL);
    assign resp_valid = (state_q == S_RESP);
    assign resp_hit   = hit_q;
    assign resp_rdata = rdata_q;
    assign fill_tag   = fill_tag_q;
    assign way_valid  = valid_q;

    // Lowest-index matching way wins when several valid ways share a tag.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (!hit && valid_q[i] && (tag_mem[i] == req_tag_q)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(i);
            end
        end
    end

    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (!inv_found && !valid_q[i]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(i);
            end
        end
    end

    assign acc_en  = ((state_q == S_LOOKUP) && hit) || ((state_q == S_FILL) && fill_valid);
    assign acc_way = (state_q == S_LOOKUP) ? hit_way : victim_q;

`ifdef CACHE_SET_LRU_EN
    logic [WAY_W-1:0] age_q [WAYS];
    logic [WAY_W-1:0] age_d [WAYS];

    always_comb begin
        policy_victim = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (age_q[i] == WAY_W'(WAYS - 1)) begin
                policy_victim = WAY_W'(i);
            end
        end
    end

    // Ways younger than the touched one age by one; the touched way becomes youngest.
    always_comb begin
        for (int i = 0; i < WAYS; i++) begin
            age_d[i] = age_q[i];
            if (acc_en) begin
                if (WAY_W'(i) == acc_way) begin
                    age_d[i] = '0;
                end else if (age_q[i] < age_q[acc_way]) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WAYS; i++) begin
                age_q[i] <= WAY_W'(i);
            end
        end else begin
            for (int i = 0; i < WAYS; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end
`else
    logic [WAY_W-1:0] rr_ptr_q, rr_ptr_d;

    assign policy_victim = rr_ptr_q;

    // The pointer only moves when a fill evicts a live line.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if ((state_q == S_FILL) && fill_valid && valid_q[victim_q]) begin
            rr_ptr_d = rr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        req_write_d = req_write_q;
        req_tag_d   = req_tag_q;
        req_off_d   = req_off_q;
        req_wdata_d = req_wdata_q;
        valid_d     = valid_q;
        victim_d    = victim_q;
        rdata_d     = rdata_q;
        hit_d       = hit_q;
        fill_tag_d  = fill_tag_q;
        line_we     = 1'b0;
        word_we     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end else if (req_valid) begin
                    req_write_d = req_write;
                    req_tag_d   = req_tag;
                    req_off_d   = req_offset;
                    req_wdata_d = req_wdata;
                    state_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    word_we = req_write_q;
                    rdata_d = req_write_q ? req_wdata_q : data_mem[hit_way][req_off_q];
                    hit_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    victim_d   = inv_found ? inv_way : policy_victim;
                    fill_tag_d = req_tag_q;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (fill_valid) begin
                    line_we           = 1'b1;
                    valid_d[victim_q] = 1'b1;
                    rdata_d           = req_write_q ? req_wdata_q
                                                    : fill_data[req_off_q*WORD_W +: WORD_W];
                    hit_d             = 1'b0;
                    state_d           = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            req_write_q <= 1'b0;
            req_tag_q   <= '0;
            req_off_q   <= '0;
            req_wdata_q <= '0;
            valid_q     <= '0;
            victim_q    <= '0;
            rdata_q     <= '0;
            hit_q       <= 1'b0;
            fill_tag_q  <= '0;
        end else begin
            state_q     <= state_d;
            req_write_q <= req_write_d;
            req_tag_q   <= req_tag_d;
            req_off_q   <= req_off_d;
            req_wdata_q <= req_wdata_d;
            valid_q     <= valid_d;
            victim_q    <= victim_d;
            rdata_q     <= rdata_d;
            hit_q       <= hit_d;
            fill_tag_q  <= fill_tag_d;
        end
    end

    // Write-allocate: the requested word takes the write data instead of the fetched word.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_mem[victim_q] <= req_tag_q;
            for (int i = 0; i < WORDS_PER_LINE; i++) begin
                data_mem[victim_q][i] <= (req_write_q && (req_off_q == OFF_W'(i)))
                                         ? req_wdata_q
                                         : fill_data[i*WORD_W +: WORD_W];
            end
        end
        if (word_we) begin
            data_mem[hit_way][req_off_q] <= req_wdata_q;
        end
    end

endmodule

// File: tb/tb_cache_set_nway.sv
// Directed-vector bench for cache_set_nway with default parameters; expectations follow the
// replacement policy selected by CACHE_SET_LRU_EN.
module tb_cache_set_nway;

    localparam int LINE_W = 16 * 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [24:0]       req_tag;
    logic [3:0]        req_offset;
    logic [31:0]       req_wdata;
    logic              flush;
    logic              resp_valid;
    logic              resp_hit;
    logic [31:0]       resp_rdata;
    logic              fill_req;
    logic [24:0]       fill_tag;
    logic              fill_valid;
    logic [LINE_W-1:0] fill_data;
    logic [7:0]        way_valid;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    cache_set_nway dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_tag    (req_tag),
        .req_offset (req_offset),
        .req_wdata  (req_wdata),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_hit   (resp_hit),
        .resp_rdata (resp_rdata),
        .fill_req   (fill_req),
        .fill_tag   (fill_tag),
        .fill_valid (fill_valid),
        .fill_data  (fill_data),
        .way_valid  (way_valid)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word i of the line for a tag is {tag[15:0], i[15:0]}.
    function automatic logic [LINE_W-1:0] make_line(input logic [24:0] tag);
        logic [LINE_W-1:0] l;
        for (int i = 0; i < 16; i++) begin
            l[i*32 +: 32] = {tag[15:0], 16'(i)};
        end
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic wr, input logic [24:0] tag, input logic [3:0] off,
                          input logic [31:0] wd, input logic exp_hit,
                          input logic [31:0] exp_rdata, input logic [LINE_W-1:0] line,
                          input int fill_delay);
        check_eq("req_ready_idle", req_ready, 1);
        req_valid  = 1'b1;
        req_write  = wr;
        req_tag    = tag;
        req_offset = off;
        req_wdata  = wd;
        tick();
        req_valid = 1'b0;
        check_eq("lookup_no_resp", resp_valid, 0);
        check_eq("lookup_ready_low", req_ready, 0);
        tick();
        if (exp_hit) begin
            check_eq("hit_resp_valid", resp_valid, 1);
            check_eq("hit_resp_hit", resp_hit, 1);
            check_eq("hit_rdata", resp_rdata, exp_rdata);
            check_eq("hit_no_fill_req", fill_req, 0);
        end else begin
            check_eq("miss_fill_req", fill_req, 1);
            check_eq("miss_fill_tag", fill_tag, tag);
            check_eq("miss_no_resp", resp_valid, 0);
            for (int d = 0; d < fill_delay; d++) begin
                tick();
                check_eq("fill_req_held", fill_req, 1);
            end
            fill_valid = 1'b1;
            fill_data  = line;
            tick();
            fill_valid = 1'b0;
            check_eq("fill_resp_valid", resp_valid, 1);
            check_eq("fill_resp_hit", resp_hit, 0);
            check_eq("fill_rdata", resp_rdata, exp_rdata);
            check_eq("fill_req_dropped", fill_req, 0);
        end
        tick();
        check_eq("ready_after_resp", req_ready, 1);
        check_eq("resp_pulse_one", resp_valid, 0);
        $display("req wr=%0d tag=0x%07h off=%0d exp_hit=%0d rdata=0x%08h way_valid=0x%02h",
                 wr, tag, off, exp_hit, resp_rdata, way_valid);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        logic [LINE_W-1:0] line;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_tag    = '0;
        req_offset = '0;
        req_wdata  = '0;
        flush      = 1'b0;
        fill_valid = 1'b0;
        fill_data  = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_resp_valid", resp_valid, 0);
        check_eq("rst_resp_hit", resp_hit, 0);
        check_eq("rst_resp_rdata", resp_rdata, 0);
        check_eq("rst_fill_req", fill_req, 0);
        check_eq("rst_fill_tag", fill_tag, 0);
        check_eq("rst_way_valid", way_valid, 0);

        // Read miss, then hit on the same word.
        line = make_line(25'h0000123);
        line[3*32 +: 32] = 32'hDEADBEEF;
        do_req(1'b0, 25'h0000123, 4'd3, 32'h0, 1'b0, 32'hDEADBEEF, line, 2);
        check_eq("way_valid_one", way_valid, 8'h01);
        do_req(1'b0, 25'h0000123, 4'd3, 32'h0, 1'b1, 32'hDEADBEEF, line, 0);

        // Write hit, read back, write-allocate miss.
        do_req(1'b1, 25'h0000123, 4'd3, 32'h12345678, 1'b1, 32'h12345678, line, 0);
        do_req(1'b0, 25'h0000123, 4'd3, 32'h0, 1'b1, 32'h12345678, line, 0);
        do_req(1'b0, 25'h0000123, 4'd4, 32'h0, 1'b1, 32'h01230004, line, 0);
        do_req(1'b1, 25'h0000200, 4'd0, 32'hA5A5A5A5, 1'b0, 32'hA5A5A5A5,
               make_line(25'h0000200), 0);
        check_eq("way_valid_two", way_valid, 8'h03);
        do_req(1'b0, 25'h0000200, 4'd0, 32'h0, 1'b1, 32'hA5A5A5A5, line, 0);
        do_req(1'b0, 25'h0000200, 4'd1, 32'h0, 1'b1, 32'h02000001, line, 0);

        // Stray fill_valid while idle must not produce a response.
        fill_valid = 1'b1;
        fill_data  = make_line(25'h0000777);
        tick();
        fill_valid = 1'b0;
        check_eq("stray_fill_no_resp", resp_valid, 0);
        check_eq("stray_fill_ready", req_ready, 1);
        check_eq("stray_fill_valids", way_valid, 8'h03);

        // Replacement policy: fill tags 0..7, touch tag 0, then miss on tag 8.
        do_reset();
        for (int k = 0; k < 8; k++) begin
            do_req(1'b0, 25'(k), 4'd1, 32'h0, 1'b0, {16'(k), 16'h0001}, make_line(25'(k)), 0);
        end
        check_eq("way_valid_full", way_valid, 8'hFF);
        do_req(1'b0, 25'd0, 4'd2, 32'h0, 1'b1, 32'h00000002, line, 0);
        do_req(1'b0, 25'd8, 4'd0, 32'h0, 1'b0, 32'h00080000, make_line(25'd8), 0);
`ifdef CACHE_SET_LRU_EN
        do_req(1'b0, 25'd0, 4'd5, 32'h0, 1'b1, 32'h00000005, line, 0);
        do_req(1'b0, 25'd1, 4'd5, 32'h0, 1'b0, 32'h00010005, make_line(25'd1), 0);
`else
        do_req(1'b0, 25'd0, 4'd5, 32'h0, 1'b0, 32'h00000005, make_line(25'd0), 0);
        do_req(1'b0, 25'd2, 4'd5, 32'h0, 1'b1, 32'h00020005, line, 0);
`endif
        check_eq("way_valid_still_full", way_valid, 8'hFF);

        // Flush wins over a simultaneous request.
        flush      = 1'b1;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_tag    = 25'd8;
        req_offset = 4'd0;
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        check_eq("flush_valids", way_valid, 8'h00);
        check_eq("flush_not_accepted", req_ready, 1);
        $display("flush way_valid=0x%02h req_ready=%0d", way_valid, req_ready);
        do_req(1'b0, 25'd8, 4'd0, 32'h0, 1'b0, 32'h00080000, make_line(25'd8), 0);
        do_req(1'b0, 25'h0000123, 4'd3, 32'h0, 1'b0, 32'h01230003, make_line(25'h0000123), 0);

        // Asynchronous reset in the middle of a fill.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_tag    = 25'h0000055;
        req_offset = 4'd0;
        tick();
        req_valid = 1'b0;
        tick();
        check_eq("pre_rst_fill_req", fill_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("midrst_fill_req", fill_req, 0);
        check_eq("midrst_way_valid", way_valid, 8'h00);
        check_eq("midrst_req_ready", req_ready, 1);
        check_eq("midrst_resp_valid", resp_valid, 0);
        tick();
        reset = 1'b0;
        fill_valid = 1'b1;
        fill_data  = make_line(25'h0000055);
        tick();
        fill_valid = 1'b0;
        check_eq("postrst_no_resp", resp_valid, 0);
        tick();
        check_eq("postrst_no_resp2", resp_valid, 0);
        check_eq("postrst_fill_req", fill_req, 0);
        check_eq("postrst_way_valid", way_valid, 8'h00);
        $display("reset-in-fill fill_req=%0d resp_valid=%0d way_valid=0x%02h",
                 fill_req, resp_valid, way_valid);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
